// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: op encoding,
// sequencer states and the counter-width helper.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Bits needed to hold a step count from 0 up to width inclusive.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Ops that move bits and are therefore worth repeating in a sequence;
  // HOLD, LOAD and the reserved code finish a sequence immediately.
  function automatic logic is_multi_step(input op_e op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One step of the universal shifter: purely combinational next-q for a
// given op. Shared by the single-step path and the multi-step sequencer.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic [WIDTH-1:0] p,
  input  logic             sir,
  input  logic             sil,
  output logic [WIDTH-1:0] q_next
);

  // Select the next register value for the requested op.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred even if an op is added without an arm.
    q_next = q;
    case (op)
      OP_SHR:  q_next = {sir, q[WIDTH-1:1]};
      OP_SHL:  q_next = {q[WIDTH-2:0], sil};
      OP_LOAD: q_next = p;
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register with single-step operation and a
// multi-step shift-by-amount sequencer (start/busy/done handshake).
// Optional build macro SHIFTREG_PARITY_EN adds a parity output (XOR of q).
module univ_shift_reg_n
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = shift_pkg::calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [2:0]       op,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] p,
  input  logic             sir,
  input  logic             sil,
  output logic [WIDTH-1:0] q,
`ifdef SHIFTREG_PARITY_EN
  output logic             parity,
`endif
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  op_e              op_in;
  op_e              step_op;
  logic [WIDTH-1:0] step_q;

  assign op_in = op_e'(op);

  // While busy the latched op drives the step; when idle the live op does.
  assign step_op = (state_q == ST_BUSY) ? op_q : op_in;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q      (q_q),
    .op     (step_op),
    .p      (p),
    .sir    (sir),
    .sil    (sil),
    .q_next (step_q)
  );

  // Next-state logic: idle accepts start (priority) or a single step,
  // busy repeats the latched op until the counter runs out.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op_in;
          if ((amount == '0) || !is_multi_step(op_in)) begin
            // Degenerate sequence: finishes now; only LOAD changes q.
            if (op_in == OP_LOAD) q_d = step_q;
            done_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = amount;
          end
        end else if (en) begin
          q_d = step_q;
        end
      end
      ST_BUSY: begin
        q_d   = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with immediate asynchronous clear of all state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == ST_BUSY);
  assign done = done_q;

`ifdef SHIFTREG_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Self-checking bench for univ_shift_reg_n (WIDTH=8): table-driven single
// steps plus hand-written sequences for reset, latency and handshake.
module tb_univ_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             clear_n;
  logic [2:0]       op;
  logic             en;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] p;
  logic             sir;
  logic             sil;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef SHIFTREG_PARITY_EN
  logic             parity;
`endif

  int checks = 0;
  int errors = 0;

  univ_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .op      (op),
    .en      (en),
    .start   (start),
    .amount  (amount),
    .p       (p),
    .sir     (sir),
    .sil     (sil),
    .q       (q),
`ifdef SHIFTREG_PARITY_EN
    .parity  (parity),
`endif
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       en;
    logic [7:0] p;
    logic       sir;
    logic       sil;
    logic [7:0] exp_q;
  } vec_t;

  task automatic check_q(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    op = 3'b011; p = v; en = 1'b1; start = 1'b0;
    tick();
    en = 1'b0; op = 3'b000;
  endtask

  // Start a sequence and wait (bounded) for done; checks latency = amt+1
  // edges counting the start edge, final q, busy use and done pulse width.
  task automatic run_seq(input logic [2:0] o, input logic [3:0] amt,
                         input logic [7:0] exp_q, input string name);
    int   edges;
    logic saw_busy;
    logic exp_busy;
    exp_busy = (amt != 4'd0);
    op = o; amount = amt; start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0; op = 3'b000;
    edges = 1;
    saw_busy = busy;
    while (!done && edges < 40) begin
      tick();
      edges++;
      saw_busy = saw_busy | busy;
    end
    check_b({name, "_done"}, done, 1'b1);
    check_q({name, "_latency"}, 8'(edges), 8'(amt) + 8'd1);
    check_q({name, "_q"}, q, exp_q);
    check_b({name, "_busy_seen"}, saw_busy, exp_busy);
    tick();
    check_b({name, "_done_clr"}, done, 1'b0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'b011, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5}; // LOAD
    vecs[1]  = '{3'b001, 1'b1, 8'h00, 1'b0, 1'b0, 8'h52}; // SHR sir=0
    vecs[2]  = '{3'b010, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5}; // SHL sil=1
    vecs[3]  = '{3'b110, 1'b1, 8'h00, 1'b0, 1'b0, 8'hD2}; // ASR
    vecs[4]  = '{3'b101, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5}; // ROL
    vecs[5]  = '{3'b111, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5}; // reserved
    vecs[6]  = '{3'b100, 1'b1, 8'h00, 1'b0, 1'b0, 8'hD2}; // ROR
    vecs[7]  = '{3'b000, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hD2}; // HOLD
    vecs[8]  = '{3'b001, 1'b0, 8'h00, 1'b1, 1'b0, 8'hD2}; // en=0
    vecs[9]  = '{3'b001, 1'b1, 8'h00, 1'b1, 1'b0, 8'hE9}; // SHR sir=1
    vecs[10] = '{3'b010, 1'b1, 8'h00, 1'b0, 1'b0, 8'hD2}; // SHL sil=0
    vecs[11] = '{3'b011, 1'b1, 8'h81, 1'b0, 1'b0, 8'h81}; // LOAD

    clear_n = 1'b0;
    op = 3'b000; en = 1'b0; start = 1'b0; amount = '0;
    p = '0; sir = 1'b0; sil = 1'b0;
    #12;
    check_q("reset_q", q, 8'h00);
    check_b("reset_busy", busy, 1'b0);
    check_b("reset_done", done, 1'b0);
`ifdef SHIFTREG_PARITY_EN
    check_b("reset_parity", parity, 1'b0);
`endif
    clear_n = 1'b1;

    // Single steps from the table.
    for (int i = 0; i < 12; i++) begin
      op = vecs[i].op; en = vecs[i].en; p = vecs[i].p;
      sir = vecs[i].sir; sil = vecs[i].sil; start = 1'b0;
      tick();
      check_q($sformatf("step%0d_q", i), q, vecs[i].exp_q);
      check_b($sformatf("step%0d_busy", i), busy, 1'b0);
      check_b($sformatf("step%0d_done", i), done, 1'b0);
    end
    en = 1'b0; sir = 1'b0; sil = 1'b0;

    // ROR by 3 on 8'h81: busy for three cycles, then q and done together.
    op = 3'b100; amount = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    check_b("ror3_busy0", busy, 1'b1);
    check_q("ror3_hold_at_start", q, 8'h81);
    tick();
    check_b("ror3_busy1", busy, 1'b1);
    check_q("ror3_q1", q, 8'hC0);
    tick();
    check_b("ror3_busy2", busy, 1'b1);
    check_b("ror3_nodone2", done, 1'b0);
    tick();
    check_b("ror3_idle", busy, 1'b0);
    check_b("ror3_done", done, 1'b1);
    check_q("ror3_q", q, 8'h30);
    tick();
    check_b("ror3_done_clr", done, 1'b0);
    check_q("ror3_q_kept", q, 8'h30);

    // Boundaries.
    run_seq(3'b010, 4'd0, 8'h30, "shl_amt0");
    load(8'h01);
    run_seq(3'b101, 4'd9, 8'h02, "rol_amt9");
    load(8'hFF);
    sir = 1'b0;
    run_seq(3'b001, 4'd12, 8'h00, "shr_amt12");
    load(8'h04);
    sir = 1'b1;
    run_seq(3'b001, 4'd2, 8'hC1, "shr_sir_live");
    sir = 1'b0;

    // Start during busy is dropped; start in the done cycle is accepted.
    load(8'h01);
    op = 3'b010; amount = 4'd4; sil = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_b("hs_busy1", busy, 1'b1);
    op = 3'b011; p = 8'hAA; amount = 4'd1; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    check_b("hs_ignored_busy", busy, 1'b1);
    check_q("hs_ignored_q", q, 8'h04);
    tick();
    check_b("hs_busy3", busy, 1'b1);
    tick();
    check_b("hs_done", done, 1'b1);
    check_q("hs_q", q, 8'h10);
    op = 3'b100; amount = 4'd2; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    check_b("b2b_busy", busy, 1'b1);
    check_b("b2b_done_clr", done, 1'b0);
    check_q("b2b_q0", q, 8'h10);
    tick();
    check_q("b2b_q1", q, 8'h08);
    tick();
    check_b("b2b_done", done, 1'b1);
    check_q("b2b_q", q, 8'h04);

    // Asynchronous clear mid-sequence (busy, counter=3), between edges.
    load(8'h3C);
    op = 3'b100; amount = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    tick();
    tick();
    check_b("rst_pre_busy", busy, 1'b1);
    #3;
    clear_n = 1'b0;
    #1;
    check_q("rst_async_q", q, 8'h00);
    check_b("rst_async_busy", busy, 1'b0);
    check_b("rst_async_done", done, 1'b0);
    #1;
    clear_n = 1'b1;
    tick();
    check_b("rst_after_busy", busy, 1'b0);
    check_q("rst_after_q", q, 8'h00);

`ifdef SHIFTREG_PARITY_EN
    load(8'h07);
    check_b("parity_07", parity, 1'b1);
    load(8'h03);
    check_b("parity_03", parity, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
